aes_round_ctrl: RTL
===================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10; number of cipher rounds, with NR=10 for AES-128.
REQ-002 Parameter DP_LAT, default 1, range 1..15; cycles that the round datapath needs per round.
REQ-003 clk  in  1  single clock; every flop updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  plaintext block offered.
REQ-006 in_ready  out  1  controller accepts a block.
REQ-007 in_block  in  128  plaintext.
REQ-008 out_valid  out  1  ciphertext available.
REQ-009 out_ready  in  1  consumer accepts the ciphertext.
REQ-010 out_block  out  128  ciphertext.
REQ-011 busy  out  1  a block is in flight, i.e. the FSM is not in IDLE.
REQ-012 key_idx  out  4  round-key index presented to the external key store.
REQ-013 round_key  in  128  key-store data for key_idx; combinational, valid in the same cycle.
REQ-014 dp_start  out  1  one-cycle pulse that begins a datapath round.
REQ-015 dp_final  out  1  current round is the final round; the datapath skips MixColumns.
REQ-016 dp_state  out  128  round input state sent to the datapath.
REQ-017 dp_key  out  128  round key sent to the datapath; equals round_key.
REQ-018 dp_result  in  128  round output returned by the datapath.

Function
REQ-019 The FSM SHALL have the states IDLE, INIT, ROUND and DONE.
REQ-020 in_ready SHALL be 1 exactly in IDLE and SHALL depend only on registered state.
REQ-021 IDLE: when in_valid=1 (acceptance), the controller SHALL load state_reg with in_block, set round_cnt=1, and go to INIT.
REQ-022 INIT: key_idx SHALL be 0; state_reg SHALL become state_reg XOR round_key; lat_cnt SHALL clear; the FSM SHALL go to ROUND.
REQ-023 ROUND: key_idx SHALL equal round_cnt; dp_state SHALL equal state_reg; both SHALL stay stable for DP_LAT cycles.
REQ-024 dp_start SHALL be 1 only in the first ROUND cycle of each round (lat_cnt=0).
REQ-025 dp_final SHALL be 1 for all ROUND cycles in which round_cnt=NR, and 0 otherwise.
REQ-026 In the ROUND cycle where lat_cnt=DP_LAT-1, state_reg SHALL capture dp_result and lat_cnt SHALL clear.
REQ-027 In that same capture cycle: if round_cnt<NR, round_cnt SHALL increment; if round_cnt=NR, the FSM SHALL go to DONE.
REQ-028 In every other ROUND cycle, lat_cnt SHALL increment.
REQ-029 DONE: out_valid=1 and out_block=state_reg, held stable until out_ready=1.
REQ-030 DONE with out_ready=1: the FSM SHALL go to IDLE; out_valid SHALL fall in the next cycle.
REQ-031 in_ready SHALL NOT rise in the same cycle as the out handshake (no combinational pass-through); it rises in the next cycle.
REQ-032 out_block SHALL equal state_reg in every state.
REQ-033 When the FSM is not in ROUND, dp_start and dp_final SHALL be 0.
REQ-034 In IDLE and DONE, key_idx SHALL be 0.
REQ-035 Latency: acceptance in cycle 0 → INIT in cycle 1 → ROUND in cycles 2..1+NR*DP_LAT → out_valid first in cycle 2+NR*DP_LAT.
REQ-036 Throughput: the controller SHALL hold one block at a time, with a minimum spacing of 3+NR*DP_LAT cycles between acceptances.
REQ-037 in_valid and in_block SHALL be ignored whenever the FSM is not in IDLE.
REQ-038 round_cnt SHALL be 4 bits and lat_cnt 4 bits; neither SHALL wrap past NR or DP_LAT-1.

Reset
REQ-039 rst=1 SHALL set, in the next cycle: FSM=IDLE, state_reg=0, round_cnt=0, lat_cnt=0.
REQ-040 While rst=1, the controller SHALL drive out_valid=0, dp_start=0, dp_final=0, key_idx=0 and busy=0; in_ready SHALL be 1 one cycle after rst deasserts.
REQ-041 Reset mid-operation SHALL abort the block: no out_valid for the aborted block and no residual dp_start.
REQ-042 rst SHALL override simultaneous handshakes: neither an acceptance nor an output handshake in that cycle takes effect.

Verification
REQ-043 FIPS-197 vector, with a behavioural AES round model on dp_* and a key-store model for key 000102030405060708090a0b0c0d0e0f: in_block 00112233445566778899aabbccddeeff → out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid first in cycle 12 for NR=10, DP_LAT=1.
REQ-044 DP_LAT=3, same vector → identical ciphertext; out_valid in cycle 32; exactly 10 dp_start pulses spaced 3 cycles apart; dp_final high for cycles 29..31.
REQ-045 out_ready held 0 for 5 cycles after out_valid → out_block stable and in_ready=0 throughout; after the handshake, in_ready=1 one cycle later.
REQ-046 Two blocks back-to-back, with in_valid held high and out_ready=1 → second acceptance exactly 13 cycles after the first (DP_LAT=1); both ciphertexts correct.
REQ-047 rst pulsed during round 5 → the next cycle shows IDLE, out_valid=0 and busy=0; a fresh block afterwards encrypts correctly.
REQ-048 in_valid toggled while busy with a different in_block → no effect on the result; key_idx sequence is 0,1,2,...,10.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module      : aes_round_ctrl
// Description : Round sequencer for an iterative AES core with an external
//               round datapath and key store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_ctrl #(
    parameter int NR     = 10,
    parameter int DP_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         dp_start,
    output logic         dp_final,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    input  logic [127:0] dp_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    localparam logic [3:0] NR_LAST  = 4'(NR);
    localparam logic [3:0] LAT_LAST = 4'(DP_LAT - 1);

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_reg_q, state_reg_d;
    logic [3:0]   round_cnt_q, round_cnt_d;
    logic [3:0]   lat_cnt_q, lat_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_reg_q <= '0;
            round_cnt_q <= '0;
            lat_cnt_q   <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_reg_q <= state_reg_d;
            round_cnt_q <= round_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_reg_d = state_reg_q;
        round_cnt_d = round_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        key_idx     = 4'd0;
        dp_start    = 1'b0;
        dp_final    = 1'b0;
        out_valid   = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_reg_d = in_block;
                    round_cnt_d = 4'd1;
                    fsm_d       = INIT;
                end
            end
            INIT: begin
                state_reg_d = state_reg_q ^ round_key;
                lat_cnt_d   = 4'd0;
                fsm_d       = ROUND;
            end
            ROUND: begin
                key_idx  = round_cnt_q;
                dp_start = (lat_cnt_q == 4'd0);
                dp_final = (round_cnt_q == NR_LAST);
                // Datapath output is only trusted on the last latency cycle.
                if (lat_cnt_q == LAT_LAST) begin
                    state_reg_d = dp_result;
                    lat_cnt_d   = 4'd0;
                    if (round_cnt_q < NR_LAST) begin
                        round_cnt_d = round_cnt_q + 4'd1;
                    end else begin
                        fsm_d = DONE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        // Reset masks the strobes immediately so an aborted block leaks nothing.
        if (rst) begin
            key_idx   = 4'd0;
            dp_start  = 1'b0;
            dp_final  = 1'b0;
            out_valid = 1'b0;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE) && !rst;
    assign out_block = state_reg_q;
    assign dp_state  = state_reg_q;
    assign dp_key    = round_key;

endmodule

`default_nettype wire
